core_result_dumper: RTL and testbench

- Synthesizable post-run readback engine sitting on the core's console port (con_write/con_addr/con_in/con_out).
- Monitors the IF-stage instruction stream and detects program end: a run of consecutive NOPs, or a self-looping jump.
- Tracks the highest data-memory word written by stores during the run.
- After the halt it walks data memory from address 0 to that highest word and streams each word out over a valid/ready interface (UART bridge or answer-key checker).

---
 rtl/core_result_dumper_if.sv | 36 +++
 rtl/core_result_dumper.sv | 174 +++++++++++++++++
 tb/tb_core_result_dumper.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_result_dumper_if.sv
`default_nettype none
// ============================================================================
//  Module   : core_result_dumper_if
//  Purpose  : Valid/ready word stream carrying the post-run memory dump
//             (address, data, last-word flag) out of core_result_dumper.
//  Revision : 1.0 - initial release
// ============================================================================
interface core_result_dumper_if #(
    parameter int ADDR_BITS  = 11,
    parameter int WORD_WIDTH = 32
);
    logic                  dump_valid;
    logic                  dump_ready;
    logic [ADDR_BITS-1:0]  dump_addr;
    logic [WORD_WIDTH-1:0] dump_data;
    logic                  dump_last;

    // Producer side: the dumper engine
    modport master (
        output dump_valid,
        output dump_addr,
        output dump_data,
        output dump_last,
        input  dump_ready
    );

    // Consumer side: UART bridge or answer-key checker
    modport slave (
        input  dump_valid,
        input  dump_addr,
        input  dump_data,
        input  dump_last,
        output dump_ready
    );
endinterface
`default_nettype wire

// File: rtl/core_result_dumper.sv
`default_nettype none
// ============================================================================
//  Module   : core_result_dumper
//  Purpose  : Watches the IF instruction stream for program end (NOP run or
//             self-looping instruction), tracks the highest stored data word,
//             then reads data memory 0..max through the console port and
//             streams every word out over a valid/ready interface.
//  Revision : 1.0 - initial release
// ============================================================================
module core_result_dumper #(
    parameter int                   WORD_WIDTH = 32,
    parameter int                   ADDR_BITS  = 11,
    parameter logic [ADDR_BITS-1:0] ADDR_LIMIT = 11'h400,
    parameter int                   NOP_LIMIT  = 10,
    parameter int                   LOOP_LIMIT = 50,
    parameter int                   CNT_WIDTH  = 32
) (
    input  wire logic                  CLK,
    input  wire logic                  nrst,
    input  wire logic [31:0]           if_inst,
    input  wire logic                  exe_store,
    input  wire logic [ADDR_BITS-1:0]  exe_word_addr,
    output logic      [3:0]            con_write,
    output logic      [WORD_WIDTH-1:0] con_in,
    output logic      [ADDR_BITS-1:0]  con_addr,
    input  wire logic [WORD_WIDTH-1:0] con_out,
    core_result_dumper_if.master       dump,
    output logic                       halted,
    output logic                       dump_done,
    output logic      [CNT_WIDTH-1:0]  run_cycles
);

    // One spare bit so a counter sitting at its limit can never wrap
    localparam int c_NOP_W  = $clog2(NOP_LIMIT + 1) + 1;
    localparam int c_LOOP_W = $clog2(LOOP_LIMIT + 1) + 1;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_READ  = 3'd1,
        ST_OFFER = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic [31:0]           r_last_inst;
    logic [c_NOP_W-1:0]    r_nop_run;
    logic [c_LOOP_W-1:0]   r_same_run;
    logic [ADDR_BITS-1:0]  r_max_addr;
    logic [ADDR_BITS-1:0]  r_cur_addr;
    logic [ADDR_BITS-1:0]  r_con_addr;
    logic [CNT_WIDTH-1:0]  r_run_cycles;
    logic                  r_halted;
    logic                  r_dump_done;
    logic                  r_valid;
    logic [ADDR_BITS-1:0]  r_dump_addr;
    logic [WORD_WIDTH-1:0] r_dump_data;
    logic                  r_dump_last;

    logic                  w_last_nop;
    logic                  w_inst_nop;
    logic                  w_halt;

    // Both the compressed C.NOP and the canonical addi x0,x0,0 count as NOP
    function automatic logic f_is_nop(input logic [31:0] inst);
        return (inst[15:0] == 16'h0001) || (inst == 32'h0000_0013);
    endfunction

    // Halt decision uses the registered run counts
    always_comb begin
        w_last_nop = f_is_nop(r_last_inst);
        w_inst_nop = f_is_nop(if_inst);
        w_halt     = (r_nop_run == c_NOP_W'(NOP_LIMIT)) ||
                     (r_same_run == c_LOOP_W'(LOOP_LIMIT));
    end

    // Main controller: halt detection, store tracking and the readback walk
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            r_state      <= ST_RUN;
            r_last_inst  <= '0;
            r_nop_run    <= '0;
            r_same_run   <= '0;
            r_max_addr   <= '0;
            r_cur_addr   <= '0;
            r_con_addr   <= '0;
            r_run_cycles <= '0;
            r_halted     <= 1'b0;
            r_dump_done  <= 1'b0;
            r_valid      <= 1'b0;
            r_dump_addr  <= '0;
            r_dump_data  <= '0;
            r_dump_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (r_run_cycles != {CNT_WIDTH{1'b1}}) begin
                        r_run_cycles <= r_run_cycles + CNT_WIDTH'(1);
                    end
                    // Words at or beyond ADDR_LIMIT are not data memory
                    if (exe_store && (exe_word_addr > r_max_addr) &&
                        (exe_word_addr < ADDR_LIMIT)) begin
                        r_max_addr <= exe_word_addr;
                    end
                    // A NOP following a NOP extends the run even if the two
                    // encodings differ; last_inst keeps the first of the run
                    if (w_last_nop && w_inst_nop) begin
                        r_nop_run  <= r_nop_run + c_NOP_W'(1);
                        r_same_run <= r_same_run + c_LOOP_W'(1);
                    end else if (if_inst == r_last_inst) begin
                        r_same_run <= r_same_run + c_LOOP_W'(1);
                    end else begin
                        r_last_inst <= if_inst;
                        r_nop_run   <= '0;
                        r_same_run  <= '0;
                    end
                    if (w_halt) begin
                        r_state    <= ST_READ;
                        r_halted   <= 1'b1;
                        r_cur_addr <= '0;
                        r_con_addr <= '0;
                    end
                end
                // Address is already on con_addr; memory answers next cycle
                ST_READ: begin
                    r_state <= ST_OFFER;
                end
                ST_OFFER: begin
                    r_dump_data <= con_out;
                    r_dump_addr <= r_cur_addr;
                    r_dump_last <= (r_cur_addr == r_max_addr);
                    r_valid     <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (dump.dump_ready) begin
                        r_valid <= 1'b0;
                        if (r_dump_last) begin
                            r_state     <= ST_DONE;
                            r_dump_done <= 1'b1;
                            r_dump_addr <= '0;
                            r_dump_data <= '0;
                            r_dump_last <= 1'b0;
                        end else begin
                            r_cur_addr <= r_cur_addr + ADDR_BITS'(1);
                            r_con_addr <= r_cur_addr + ADDR_BITS'(1);
                            r_state    <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // The console port is only ever read
    assign con_write       = 4'b0000;
    assign con_in          = '0;
    assign con_addr        = r_con_addr;
    assign halted          = r_halted;
    assign dump_done       = r_dump_done;
    assign run_cycles      = r_run_cycles;
    assign dump.dump_valid = r_valid;
    assign dump.dump_addr  = r_dump_addr;
    assign dump.dump_data  = r_dump_data;
    assign dump.dump_last  = r_dump_last;

endmodule
`default_nettype wire

// File: tb/tb_core_result_dumper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_result_dumper
//  Purpose  : Randomized scoreboard bench for core_result_dumper: programs are
//             evaluated by a reference model, expected dump words are queued,
//             and a monitor compares every presented word against the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_result_dumper;
    localparam int AW    = 11;
    localparam int WW    = 32;
    localparam int NOPL  = 10;
    localparam int LOOPL = 50;

    logic          CLK = 1'b0;
    logic          nrst = 1'b0;
    logic [31:0]   if_inst = '0;
    logic          exe_store = 1'b0;
    logic [AW-1:0] exe_word_addr = '0;
    logic [3:0]    con_write;
    logic [WW-1:0] con_in;
    logic [AW-1:0] con_addr;
    logic [WW-1:0] con_out = '0;
    logic          halted;
    logic          dump_done;
    logic [31:0]   run_cycles;

    always #5 CLK = ~CLK;

    core_result_dumper_if #(.ADDR_BITS(AW), .WORD_WIDTH(WW)) dif();

    core_result_dumper #(
        .WORD_WIDTH(WW), .ADDR_BITS(AW), .ADDR_LIMIT(11'h400),
        .NOP_LIMIT(NOPL), .LOOP_LIMIT(LOOPL), .CNT_WIDTH(32)
    ) dut (
        .CLK(CLK), .nrst(nrst), .if_inst(if_inst), .exe_store(exe_store),
        .exe_word_addr(exe_word_addr), .con_write(con_write), .con_in(con_in),
        .con_addr(con_addr), .con_out(con_out), .dump(dif.master),
        .halted(halted), .dump_done(dump_done), .run_cycles(run_cycles)
    );

    // Data memory with one-cycle read latency behind the console port
    logic [WW-1:0] mem [0:2047];
    always @(posedge CLK) con_out <= mem[con_addr];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [WW-1:0] d;
        logic          l;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ---------------- program and reference model ----------------
    logic [31:0]   p_inst[$];
    logic          p_st[$];
    logic [AW-1:0] p_wa[$];

    task automatic new_prog();
        p_inst.delete(); p_st.delete(); p_wa.delete();
    endtask

    task automatic add(input logic [31:0] i, input logic s, input logic [AW-1:0] a);
        p_inst.push_back(i); p_st.push_back(s); p_wa.push_back(a);
    endtask

    // Past the end of the program the core idles on addi x0,x0,0
    task automatic get(input int k, output logic [31:0] i, output logic s, output logic [AW-1:0] a);
        if (k < p_inst.size()) begin
            i = p_inst[k]; s = p_st[k]; a = p_wa[k];
        end else begin
            i = 32'h13; s = 1'b0; a = '0;
        end
    endtask

    function automatic bit is_nop(input logic [31:0] i);
        return (i[15:0] == 16'h0001) || (i == 32'h13);
    endfunction

    // Returns the RUN cycle index on whose closing edge the halt happens,
    // and the highest in-range stored word
    task automatic model(output int h, output logic [AW-1:0] mx);
        logic [31:0]   last;
        logic [31:0]   i;
        logic          s;
        logic [AW-1:0] a;
        int            nr;
        int            sr;
        last = '0; nr = 0; sr = 0; mx = '0; h = -1;
        for (int k = 0; k < 5000; k++) begin
            get(k, i, s, a);
            if (s && a > mx && a < 11'h400) mx = a;
            if (nr == NOPL || sr == LOOPL) begin
                h = k;
                break;
            end
            if (is_nop(last) && is_nop(i)) begin
                nr++; sr++;
            end else if (i == last) begin
                sr++;
            end else begin
                last = i; nr = 0; sr = 0;
            end
        end
    endtask

    // ---------------- ready generator ----------------
    int rmode = 0;
    initial begin
        int hc;
        hc = 0;
        dif.dump_ready = 1'b0;
        forever begin
            @(posedge CLK); #1;
            case (rmode)
                0: dif.dump_ready = 1'b1;
                1: dif.dump_ready = 1'($urandom_range(0, 1));
                default: begin
                    // Hold ready low for 7 valid cycles before accepting
                    if (!dif.dump_valid) begin
                        hc = 0;
                        dif.dump_ready = 1'b0;
                    end else begin
                        hc++;
                        dif.dump_ready = (hc > 7);
                    end
                end
            endcase
        end
    end

    // ---------------- monitor ----------------
    bit spc = 1'b0;
    initial begin
        int cyc;
        int last_hs;
        cyc = 0;
        last_hs = -1;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!nrst) begin
                last_hs = -1;
            end else begin
                chk("con_write_in", {con_write, con_in}, '0);
                if (dif.dump_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_word", {dif.dump_addr, dif.dump_last}, {12'hFFF, 1'b1, 1'b1});
                    end else begin
                        chk("dump_word", {dif.dump_addr, dif.dump_data, dif.dump_last}, sb[0]);
                        if (dif.dump_ready) begin
                            void'(sb.pop_front());
                            if (spc && last_hs >= 0) chk("spacing", cyc - last_hs, 3);
                            last_hs = cyc;
                        end
                    end
                end
            end
        end
    end

    // ---------------- test sequencing ----------------
    task automatic do_reset();
        nrst = 1'b0;
        if_inst = '0; exe_store = 1'b0; exe_word_addr = '0;
        sb.delete();
        spc = 1'b0;
        rmode = 0;
        @(posedge CLK); #1;
        chk("reset_state", {halted, dump_done, dif.dump_valid, dif.dump_last,
                            dif.dump_addr, con_addr, run_cycles}, '0);
        @(posedge CLK); #1;
    endtask

    task automatic drive_garbage();
        if_inst = $urandom;
        exe_store = 1'($urandom_range(0, 1));
        exe_word_addr = AW'($urandom_range(0, 2047));
    endtask

    task automatic start_test(input int mode, input bit spacing, output int h, output logic [AW-1:0] mx);
        logic [31:0]   i;
        logic          s;
        logic [AW-1:0] a;
        for (int k = 0; k < 2048; k++) mem[k] = $urandom;
        model(h, mx);
        for (int k = 0; k <= int'(mx); k++) sb.push_back({AW'(k), mem[k], (k == int'(mx))});
        rmode = mode;
        spc = spacing;
        for (int k = 0; k <= h; k++) begin
            get(k, i, s, a);
            if_inst = i; exe_store = s; exe_word_addr = a;
            nrst = 1'b1;
            if (k == h) chk("halted_before", halted, 0);
            @(posedge CLK); #1;
        end
        chk("halted", halted, 1);
        chk("run_cycles", run_cycles, h + 1);
    endtask

    task automatic finish_test(input int h, input logic [AW-1:0] mx);
        int t;
        t = 0;
        while (!dump_done && t < (int'(mx) + 1) * 16 + 50) begin
            drive_garbage();
            @(posedge CLK); #1;
            t++;
        end
        chk("dump_done", dump_done, 1);
        chk("all_words_seen", sb.size(), 0);
        chk("final_outputs", {halted, dif.dump_valid, dif.dump_last, con_addr}, {1'b1, 1'b0, 1'b0, mx});
        chk("run_cycles_frozen", run_cycles, h + 1);
    endtask

    initial begin
        int            h;
        logic [AW-1:0] mx;
        bit            found;

        // Nine stores to word 3, then a NOP run
        do_reset();
        new_prog();
        for (int i = 0; i < 9; i++) add(32'h1000_0000 + i, 1'b1, 11'd3);
        for (int i = 0; i < 11; i++) add(32'h13, 1'b0, '0);
        start_test(0, 1'b1, h, mx);
        chk("t1_halt_cycle", h, 20);
        finish_test(h, mx);

        // Self-looping jump
        do_reset();
        new_prog();
        add(32'h6F, 1'b1, 11'd1);
        for (int i = 0; i < 60; i++) add(32'h6F, 1'b0, '0);
        start_test(1, 1'b0, h, mx);
        finish_test(h, mx);

        // Store limit: 0x400 ignored, 1024 words dumped
        do_reset();
        new_prog();
        add(32'h100, 1'b1, 11'h005);
        add(32'h104, 1'b1, 11'h3FF);
        add(32'h108, 1'b1, 11'h400);
        start_test(0, 1'b1, h, mx);
        chk("t3_max_addr", mx, 11'h3FF);
        finish_test(h, mx);

        // Backpressure
        do_reset();
        new_prog();
        add(32'h200, 1'b1, 11'd2);
        start_test(2, 1'b0, h, mx);
        finish_test(h, mx);

        // No stores, C.NOP stream with varying upper halves
        do_reset();
        new_prog();
        for (int i = 0; i < 20; i++) add({16'($urandom), 16'h0001}, 1'b0, '0);
        start_test(1, 1'b0, h, mx);
        finish_test(h, mx);

        // Reset while holding word 2
        do_reset();
        new_prog();
        add(32'h300, 1'b1, 11'd5);
        start_test(2, 1'b0, h, mx);
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge CLK);
            if (dif.dump_valid && dif.dump_addr == 11'd2 && !dif.dump_ready) found = 1'b1;
        end
        chk("reach_hold_addr2", found, 1);
        @(posedge CLK); #1;
        nrst = 1'b0;
        sb.delete();
        @(posedge CLK); #1;
        chk("reset_mid_dump", {dif.dump_valid, halted, dump_done, run_cycles, con_addr}, '0);

        // Fresh random programs after the mid-dump reset
        for (int r = 0; r < 4; r++) begin
            do_reset();
            new_prog();
            for (int k = 0; k < 30; k++) begin
                logic [31:0] ins;
                logic [AW-1:0] wa;
                case ($urandom_range(0, 3))
                    0: ins = 32'h13;
                    1: ins = {16'($urandom), 16'h0001};
                    2: ins = 32'h6F;
                    default: ins = $urandom;
                endcase
                wa = ($urandom_range(0, 9) == 0) ? AW'(11'h400 + $urandom_range(0, 1023))
                                                 : AW'($urandom_range(0, 12));
                add(ins, ($urandom_range(0, 2) == 0), wa);
            end
            start_test(1, 1'b0, h, mx);
            finish_test(h, mx);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
